// File: rtl/regfile_write_injector.sv
// Regfile write-port arbiter: processor writeback vs. a small FIFO of peripheral writes.
// Optional starvation guard compiled in with `define INJ_STARVE_GUARD_EN.
module regfile_write_injector #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     proc_we,
    input  logic [4:0]               proc_wreg,
    input  logic [31:0]              proc_wdata,
    input  logic                     io_valid,
    input  logic [4:0]               io_reg,
    input  logic [31:0]              io_data,
    output logic                     io_ready,
    output logic                     ctrl_writeEnable,
    output logic [4:0]               ctrl_writeReg,
    output logic [31:0]              data_writeReg,
    output logic                     proc_stall,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Elaborates only for an illegal configuration, so a bad DEPTH/STARVE_MAX is easy to spot.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 1) begin : g_invalid_params
    end

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push;
    logic            pop;
    logic            has_entry;
    logic            force_inj;
    entry_t          head;

    assign has_entry  = (count_q != '0);
    assign io_ready   = (count_q != FULL_COUNT);
    assign push       = io_valid && io_ready && (io_reg != 5'd0);
    assign pop        = has_entry && (!proc_we || force_inj);
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;

`ifdef INJ_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign force_inj  = has_entry && (starve_q == SW'(STARVE_MAX));
    assign proc_stall = force_inj;

    // Counts cycles in which a queued entry was held off by the processor.
    always_comb begin
        starve_d = starve_q;
        if (pop || !has_entry) begin
            starve_d = '0;
        end else if (proc_we) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_inj  = 1'b0;
    assign proc_stall = 1'b0;
`endif

    always_comb begin
        ctrl_writeEnable = proc_we;
        ctrl_writeReg    = proc_wreg;
        data_writeReg    = proc_wdata;
        if (pop) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = head.wreg;
            data_writeReg    = head.wdata;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so stale entries are never visible.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{wreg: io_reg, wdata: io_data};
        end
    end

endmodule

// File: tb/tb_regfile_write_injector.sv
// Directed self-checking bench for regfile_write_injector (default DEPTH=4, STARVE_MAX=8).
// Starvation-guard scenarios run only when INJ_STARVE_GUARD_EN is defined.
module tb_regfile_write_injector;

    logic        clock;
    logic        ctrl_reset;
    logic        proc_we;
    logic [4:0]  proc_wreg;
    logic [31:0] proc_wdata;
    logic        io_valid;
    logic [4:0]  io_reg;
    logic [31:0] io_data;
    logic        io_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        proc_stall;
    logic [2:0]  fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_write_injector #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .proc_we          (proc_we),
        .proc_wreg        (proc_wreg),
        .proc_wdata       (proc_wdata),
        .io_valid         (io_valid),
        .io_reg           (io_reg),
        .io_data          (io_data),
        .io_ready         (io_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .proc_stall       (proc_stall),
        .fifo_count       (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        proc_we    = 1'b1;
        proc_wreg  = 5'd5;
        proc_wdata = 32'h0000_1234;
        io_valid   = 1'b0;
        io_reg     = 5'd0;
        io_data    = 32'h0;
        #1;
        tests_run++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'h0000_1234}) begin
            tests_failed++;
            $display("FAIL reset_write_port: got we=%b reg=%0d data=%h expected we=1 reg=5 data=00001234",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if ({fifo_count, io_ready, proc_stall} !== {3'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got count=%0d ready=%b stall=%b expected count=0 ready=1 stall=0",
                     fifo_count, io_ready, proc_stall);
        end
        tick();
        tick();
        ctrl_reset = 1'b0;
        tick();
        tests_run++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count, io_ready} !==
            {1'b1, 5'd5, 32'h0000_1234, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got we=%b reg=%0d data=%h count=%0d ready=%b expected 1/5/00001234/0/1",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count, io_ready);
        end
    endtask

    task automatic test_single_injection();
        proc_we  = 1'b0;
        io_valid = 1'b1;
        io_reg   = 5'd10;
        io_data  = 32'h0064_0032;
        #1;
        tests_run++;
        if (ctrl_writeEnable !== 1'b0) begin
            tests_failed++;
            $display("FAIL inject_no_bypass: got we=%b expected we=0 before acceptance edge", ctrl_writeEnable);
        end
        tick();
        io_valid = 1'b0;
        #1;
        tests_run++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count} !==
            {1'b1, 5'd10, 32'h0064_0032, 3'd1}) begin
            tests_failed++;
            $display("FAIL inject_write: got we=%b reg=%0d data=%h count=%0d expected 1/10/00640032/1",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count);
        end
        tick();
        tests_run++;
        if ({ctrl_writeEnable, fifo_count} !== {1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL inject_drained: got we=%b count=%0d expected we=0 count=0", ctrl_writeEnable, fifo_count);
        end
    endtask

    task automatic test_fill_to_full();
        proc_we    = 1'b1;
        proc_wreg  = 5'd3;
        proc_wdata = 32'h0000_AAAA;
        for (int i = 0; i < 4; i++) begin
            io_valid = 1'b1;
            io_reg   = 5'(i + 1);
            io_data  = 32'h0000_0100 + 32'(i);
            tick();
        end
        io_valid = 1'b1;
        io_reg   = 5'd7;
        io_data  = 32'h0000_DEAD;
        #1;
        tests_run++;
        if ({fifo_count, io_ready} !== {3'd4, 1'b0}) begin
            tests_failed++;
            $display("FAIL fill_full: got count=%0d ready=%b expected count=4 ready=0", fifo_count, io_ready);
        end
        tests_run++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'h0000_AAAA}) begin
            tests_failed++;
            $display("FAIL fill_proc_priority: got we=%b reg=%0d data=%h expected 1/3/0000aaaa",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tick();
        io_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd4) begin
            tests_failed++;
            $display("FAIL fill_fifth_refused: got count=%0d expected 4", fifo_count);
        end
        proc_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count} !==
                {1'b1, 5'(i + 1), 32'h0000_0100 + 32'(i), 3'(4 - i)}) begin
                tests_failed++;
                $display("FAIL drain_%0d: got we=%b reg=%0d data=%h count=%0d expected 1/%0d/%h/%0d",
                         i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count,
                         i + 1, 32'h0000_0100 + 32'(i), 4 - i);
            end
            tick();
        end
        tests_run++;
        if ({ctrl_writeEnable, fifo_count} !== {1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL drain_empty: got we=%b count=%0d expected we=0 count=0", ctrl_writeEnable, fifo_count);
        end
    endtask

    task automatic test_reg0_filter();
        proc_we  = 1'b0;
        io_valid = 1'b1;
        io_reg   = 5'd0;
        io_data  = 32'hFFFF_FFFF;
        #1;
        tests_run++;
        if (io_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reg0_ready: got ready=%b expected 1", io_ready);
        end
        tick();
        io_valid = 1'b0;
        #1;
        tests_run++;
        if ({ctrl_writeEnable, fifo_count} !== {1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL reg0_dropped: got we=%b count=%0d expected we=0 count=0", ctrl_writeEnable, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_reg  [4];
        logic [31:0] exp_data [4];
        exp_reg  = '{5'd11, 5'd12, 5'd13, 5'd14};
        exp_data = '{32'hB000_0011, 32'hB000_0012, 32'hB000_0013, 32'hB000_0014};
        proc_we    = 1'b1;
        proc_wreg  = 5'd11;
        proc_wdata = 32'hCAFE_0000;
        for (int i = 0; i < 2; i++) begin
            io_valid = 1'b1;
            io_reg   = exp_reg[i];
            io_data  = exp_data[i];
            tick();
        end
        tests_run++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd11, 32'hCAFE_0000}) begin
            tests_failed++;
            $display("FAIL conflict_proc_wins: got we=%b reg=%0d data=%h expected 1/11/cafe0000",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        proc_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io_valid = (i < 2);
            io_reg   = (i < 2) ? exp_reg[i + 2] : 5'd0;
            io_data  = (i < 2) ? exp_data[i + 2] : 32'h0;
            #1;
            tests_run++;
            if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count} !==
                {1'b1, exp_reg[i], exp_data[i], (i < 3) ? 3'd2 : 3'd1}) begin
                tests_failed++;
                $display("FAIL push_pop_%0d: got we=%b reg=%0d data=%h count=%0d expected 1/%0d/%h/%0d",
                         i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count,
                         exp_reg[i], exp_data[i], (i < 3) ? 2 : 1);
            end
            tick();
        end
        io_valid = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL push_pop_empty: got count=%0d expected 0", fifo_count);
        end
    endtask

    task automatic test_reset_mid_stream();
        proc_we    = 1'b1;
        proc_wreg  = 5'd6;
        proc_wdata = 32'h0000_6666;
        for (int i = 0; i < 2; i++) begin
            io_valid = 1'b1;
            io_reg   = 5'(20 + i);
            io_data  = 32'h0000_2000 + 32'(i);
            tick();
        end
        io_valid = 1'b0;
        #2;
        ctrl_reset = 1'b1;
        #1;
        tests_run++;
        if ({fifo_count, io_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !==
            {3'd0, 1'b1, 1'b1, 5'd6, 32'h0000_6666}) begin
            tests_failed++;
            $display("FAIL reset_mid_stream: got count=%0d ready=%b we=%b reg=%0d data=%h expected 0/1/1/6/00006666",
                     fifo_count, io_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tick();
        ctrl_reset = 1'b0;
        proc_we    = 1'b0;
        tick();
        tests_run++;
        if ({ctrl_writeEnable, fifo_count} !== {1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset_discard: got we=%b count=%0d expected we=0 count=0", ctrl_writeEnable, fifo_count);
        end
    endtask

`ifdef INJ_STARVE_GUARD_EN
    task automatic test_starve_guard();
        proc_we    = 1'b1;
        proc_wreg  = 5'd9;
        proc_wdata = 32'h0000_0099;
        io_valid   = 1'b1;
        io_reg     = 5'd25;
        io_data    = 32'h0000_2525;
        tick();
        io_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++;
            if ({proc_stall, ctrl_writeReg} !== {1'b0, 5'd9}) begin
                tests_failed++;
                $display("FAIL starve_blocked_%0d: got stall=%b reg=%0d expected stall=0 reg=9",
                         i, proc_stall, ctrl_writeReg);
            end
            tick();
        end
        tests_run++;
        if ({proc_stall, ctrl_writeEnable, ctrl_writeReg, data_writeReg} !==
            {1'b1, 1'b1, 5'd25, 32'h0000_2525}) begin
            tests_failed++;
            $display("FAIL starve_force: got stall=%b we=%b reg=%0d data=%h expected 1/1/25/00002525",
                     proc_stall, ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tick();
        tests_run++;
        if ({proc_stall, ctrl_writeReg, data_writeReg, fifo_count} !== {1'b0, 5'd9, 32'h0000_0099, 3'd0}) begin
            tests_failed++;
            $display("FAIL starve_retry: got stall=%b reg=%0d data=%h count=%0d expected 0/9/00000099/0",
                     proc_stall, ctrl_writeReg, data_writeReg, fifo_count);
        end
        io_valid = 1'b1;
        tick();
        io_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        tests_run++;
        if (proc_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL starve_second: got stall=%b expected 1", proc_stall);
        end
        ctrl_reset = 1'b1;
        #1;
        tests_run++;
        if ({proc_stall, ctrl_writeReg, data_writeReg, fifo_count} !== {1'b0, 5'd9, 32'h0000_0099, 3'd0}) begin
            tests_failed++;
            $display("FAIL starve_reset: got stall=%b reg=%0d data=%h count=%0d expected 0/9/00000099/0",
                     proc_stall, ctrl_writeReg, data_writeReg, fifo_count);
        end
        tick();
        ctrl_reset = 1'b0;
        proc_we    = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_injection();
        test_fill_to_full();
        test_reg0_filter();
        test_back_to_back();
        test_reset_mid_stream();
`ifdef INJ_STARVE_GUARD_EN
        test_starve_guard();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_write_injector.md
Name: regfile_write_injector

Overview:
- Write-side counterpart to the processor register file. Lets peripherals such as the guitar input and paddle/score logic push values into architectural registers through the single regfile write port.
- Arbitrates between the processor writeback path and a small FIFO of peripheral write requests. Its outputs drive the regfile's ctrl_writeEnable, ctrl_writeReg and data_writeReg.
- The processor always has priority except when the optional starvation guard is compiled in.

Parameters:
- DEPTH, 4, peripheral FIFO entries; power of two, minimum 2.
- STARVE_MAX, 8, consecutive blocked cycles before the starvation guard forces an injection (used only with the macro).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  reset, asynchronous, active-high; clears all state.
- proc_we  in  1  processor writeback enable this cycle.
- proc_wreg  in  5  processor destination register.
- proc_wdata  in  32  processor writeback data.
- io_valid  in  1  peripheral write request valid.
- io_reg  in  5  peripheral destination register.
- io_data  in  32  peripheral write data.
- io_ready  out  1  FIFO can accept; a transfer occurs on a rising edge with io_valid=1 and io_ready=1.
- ctrl_writeEnable  out  1  to regfile write enable.
- ctrl_writeReg  out  5  to regfile write select.
- data_writeReg  out  32  to regfile write data.
- proc_stall  out  1  processor must hold its writeback this cycle; constant 0 without the macro.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, asserted):
  - FIFO empty; fifo_count=0; io_ready=1; starvation counter=0; proc_stall=0.
  - Write outputs follow the processor path: ctrl_writeEnable=proc_we, ctrl_writeReg=proc_wreg, data_writeReg=proc_wdata.
  - Reset mid-stream discards all queued entries; no partial write is issued.
- FIFO:
  - Synchronous circular buffer with separate read/write pointers that wrap modulo DEPTH.
  - io_ready = (count != DEPTH). It is not a function of same-cycle pop, so a full FIFO refuses a push even when a pop occurs that cycle.
- Register-0 filter: an accepted request with io_reg==0 is consumed (io_ready honoured) but not enqueued; count is unchanged.
- Output mux (combinational, from current state and inputs):
  - If proc_we=1 and no forced injection: the processor write drives the outputs; the FIFO head is not popped.
  - Else if count>0: ctrl_writeEnable=1, outputs = FIFO head register/data, and the head pops on the rising edge.
  - Else: ctrl_writeEnable=proc_we and outputs = processor fields.
- Latency:
  - A request accepted at edge N is eligible to drive the write port in the cycle after edge N.
  - There is no empty-FIFO bypass; minimum latency is 1 cycle.
  - The regfile commits on the falling clock edge, so the value is readable in the following cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Ordering: peripheral writes commit in acceptance order. Two queued writes to the same register both commit; the last one wins.
- Same-cycle conflict (processor and FIFO head target the same register): only the winning source writes that cycle; the other writes later, so it overwrites.

Optional Feature:
- Macro: INJ_STARVE_GUARD_EN.
- With the macro defined:
  - The starvation counter increments each cycle in which count>0 and proc_we=1 blocks the pop.
  - It clears whenever a pop occurs or count==0.
  - When the counter equals STARVE_MAX, that cycle the FIFO head wins the write port, proc_stall=1 combinationally, and the counter clears on the edge.
  - The processor must hold proc_we/proc_wreg/proc_wdata and retry; its write lands the next cycle unless it is blocked again.
- Without the macro: no counter, proc_stall tied 0, and the processor has absolute priority (peripheral writes may starve indefinitely).

Test Plan:
- Reset then idle:
  - Stimulus: proc_we=1, proc_wreg=5, proc_wdata=0x1234.
  - Response: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0x1234; fifo_count=0; io_ready=1.
- Single injection, processor idle:
  - Stimulus: push (reg 10, 0x00640032) at edge N.
  - Response: in the cycle after edge N, writeEnable=1, writeReg=10, data=0x00640032; fifo_count returns to 0 after the next edge.
- Fill to full:
  - Stimulus: proc_we held at 1; push DEPTH=4 entries.
  - Response: fifo_count=4, io_ready=0; a fifth io_valid is not accepted.
  - Stimulus: release proc_we.
  - Response: the four entries drain in order over 4 cycles.
- Register-0 filter: push (reg 0, 0xFFFFFFFF) -> accepted, fifo_count stays 0, no write issued.
- Same-cycle push/pop: count=2 with proc_we=0 and a simultaneous push -> fifo_count stays 2 and ordering is preserved across pointer wrap.
- With INJ_STARVE_GUARD_EN, STARVE_MAX=8:
  - Stimulus: proc_we held at 1 with one entry queued.
  - Response: on the 9th blocked cycle, proc_stall=1 and the FIFO entry is written; the processor's held write commits the next cycle.
  - Reset asserted mid-stall: outputs return to the reset values immediately.
